uart_reg_cmd: RTL and testbench



---
 rtl/uart_reg_pkg.sv | 18 +
 rtl/uart_reg_timeout.sv | 28 ++
 rtl/uart_reg_cmd.sv | 132 +++++++++++++
 tb/tb_uart_reg_cmd.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_reg_pkg.sv
// Shared encodings for the UART register command decoder: FSM states,
// status register address and status bit positions.
package uart_reg_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    RESP      = 2'd2
  } state_t;

  localparam logic [6:0] STATUS_ADDR = 7'h7F;
  localparam int         CMD_WR_BIT  = 7;

  localparam int ST_OVERRUN = 0;
  localparam int ST_TIMEOUT = 1;
  localparam int ST_BADADDR = 2;

endpackage

// File: rtl/uart_reg_timeout.sv
// Saturating idle counter for a pending write; expire pulses on the enabled
// cycle in which the count has reached TIMEOUT_CYCLES-1.
module uart_reg_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en && (cnt != LIMIT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = en && (cnt == LIMIT);

endmodule

// File: rtl/uart_reg_cmd.sv
// Decodes received UART bytes into register write/read commands, holds the
// register file and sticky status, and hands read responses to the transmitter.
module uart_reg_cmd
  import uart_reg_pkg::*;
#(
  parameter int NUM_REGS       = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  tx_busy,
  output logic                  tx_en,
  output logic [7:0]            tx_data,
  output logic [NUM_REGS*8-1:0] regs_out,
  output logic                  wr_strobe,
  output logic [6:0]            wr_addr
);

  state_t     state, state_n;
  logic [6:0] addr_q;
  logic [2:0] status;
  logic [2:0] st_set;
  logic       st_clr;
  logic       cnt_clr, cnt_en, expire;
  logic       do_rd, do_wr, wr_hit;
  logic [7:0] rd_val;
  logic [6:0] rx_addr;

  assign rx_addr = rx_data[6:0];

  function automatic logic is_mapped(input logic [6:0] a);
    return a < 7'(NUM_REGS);
  endfunction

  uart_reg_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .expire (expire)
  );

  always_comb begin
    rd_val = 8'h00;
    if (rx_addr == STATUS_ADDR) begin
      rd_val = {5'b0, status};
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rx_addr == 7'(i)) rd_val = regs_out[i*8 +: 8];
      end
    end
  end

  always_comb begin
    state_n = state;
    tx_en   = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    do_rd   = 1'b0;
    do_wr   = 1'b0;
    st_set  = 3'b000;
    st_clr  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data[CMD_WR_BIT]) begin
            cnt_clr = 1'b1;
            state_n = WAIT_DATA;
          end else begin
            do_rd   = 1'b1;
            state_n = RESP;
            if (rx_addr == STATUS_ADDR) st_clr = 1'b1;
            else if (!is_mapped(rx_addr)) st_set[ST_BADADDR] = 1'b1;
          end
        end
      end
      WAIT_DATA: begin
        if (rx_valid) begin
          do_wr   = 1'b1;
          state_n = IDLE;
          if (addr_q == STATUS_ADDR) st_clr = 1'b1;
          else if (!is_mapped(addr_q)) st_set[ST_BADADDR] = 1'b1;
        end else begin
          cnt_en = 1'b1;
          if (expire) begin
            st_set[ST_TIMEOUT] = 1'b1;
            state_n            = IDLE;
          end
        end
      end
      RESP: begin
        // Gated by reset so an abort in RESP never launches a response.
        if (!tx_busy && !reset) begin
          tx_en   = 1'b1;
          state_n = IDLE;
        end
        if (rx_valid) st_set[ST_OVERRUN] = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign wr_hit = do_wr && (is_mapped(addr_q) || (addr_q == STATUS_ADDR));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      status    <= '0;
      tx_data   <= '0;
      regs_out  <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
    end else begin
      state     <= state_n;
      wr_strobe <= wr_hit;
      if (cnt_clr) addr_q <= rx_addr;
      if (do_rd) tx_data <= rd_val;
      // Clear first, then OR in new events so a simultaneous set survives.
      status <= (st_clr ? 3'b000 : status) | st_set;
      if (wr_hit) wr_addr <= addr_q;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (do_wr && (addr_q == 7'(i))) regs_out[i*8 +: 8] <= rx_data;
      end
    end
  end

endmodule

// File: tb/tb_uart_reg_cmd.sv
// Directed bench for uart_reg_cmd: register writes/reads, busy handshake,
// timeout, overrun, bad address and reset abort.
module tb_uart_reg_cmd;

  localparam int NUM_REGS = 4;
  localparam int TMO      = 50;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  rx_valid = 1'b0;
  logic [7:0]            rx_data = 8'h00;
  logic                  tx_busy = 1'b0;
  logic                  tx_en;
  logic [7:0]            tx_data;
  logic [NUM_REGS*8-1:0] regs_out;
  logic                  wr_strobe;
  logic [6:0]            wr_addr;

  int total = 0;
  int bad   = 0;

  uart_reg_cmd #(
    .NUM_REGS       (NUM_REGS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_busy   (tx_busy),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .regs_out  (regs_out),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    total++; if (regs_out !== 32'h0) begin bad++; $display("FAIL rst_regs got=%h want=%h", regs_out, 32'h0); end
    total++; if (tx_en !== 1'b0) begin bad++; $display("FAIL rst_tx_en got=%b want=0", tx_en); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data got=%h want=00", tx_data); end
    total++; if (wr_strobe !== 1'b0) begin bad++; $display("FAIL rst_wr_strobe got=%b want=0", wr_strobe); end
    total++; if (wr_addr !== 7'h00) begin bad++; $display("FAIL rst_wr_addr got=%h want=00", wr_addr); end
    send(8'h7F);
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_status got=%h want=00", tx_data); end
    tick();
  endtask

  task automatic test_write();
    send(8'h81);
    total++; if (wr_strobe !== 1'b0) begin bad++; $display("FAIL wr_cmd_strobe got=%b want=0", wr_strobe); end
    send(8'hA5);
    total++; if (regs_out !== 32'h0000A500) begin bad++; $display("FAIL wr_regs got=%h want=0000a500", regs_out); end
    total++; if (wr_strobe !== 1'b1) begin bad++; $display("FAIL wr_strobe got=%b want=1", wr_strobe); end
    total++; if (wr_addr !== 7'h01) begin bad++; $display("FAIL wr_addr got=%h want=01", wr_addr); end
    tick();
    total++; if (wr_strobe !== 1'b0) begin bad++; $display("FAIL wr_strobe_once got=%b want=0", wr_strobe); end
  endtask

  task automatic test_read();
    send(8'h82);
    send(8'h3C);
    send(8'h02);
    total++; if (tx_en !== 1'b1) begin bad++; $display("FAIL rd_tx_en got=%b want=1", tx_en); end
    total++; if (tx_data !== 8'h3C) begin bad++; $display("FAIL rd_tx_data got=%h want=3c", tx_data); end
    tick();
    total++; if (tx_en !== 1'b0) begin bad++; $display("FAIL rd_tx_en_once got=%b want=0", tx_en); end
    total++; if (regs_out !== 32'h003CA500) begin bad++; $display("FAIL rd_regs got=%h want=003ca500", regs_out); end
  endtask

  task automatic test_busy();
    int en_seen = 0;
    tx_busy = 1'b1;
    send(8'h01);
    for (int i = 0; i < 100; i++) begin
      if (tx_en) en_seen++;
      tick();
    end
    total++; if (en_seen !== 0) begin bad++; $display("FAIL busy_no_tx_en got=%0d want=0", en_seen); end
    tx_busy = 1'b0;
    #1;
    total++; if (tx_en !== 1'b1) begin bad++; $display("FAIL busy_release_tx_en got=%b want=1", tx_en); end
    total++; if (tx_data !== 8'hA5) begin bad++; $display("FAIL busy_tx_data got=%h want=a5", tx_data); end
    tick();
    total++; if (tx_en !== 1'b0) begin bad++; $display("FAIL busy_tx_en_once got=%b want=0", tx_en); end
  endtask

  task automatic test_timeout();
    send(8'h80);
    tick(TMO + 5);
    total++; if (regs_out !== 32'h003CA500) begin bad++; $display("FAIL tmo_regs got=%h want=003ca500", regs_out); end
    send(8'h7F);
    total++; if (tx_data !== 8'h02) begin bad++; $display("FAIL tmo_status got=%h want=02", tx_data); end
    tick();
    send(8'h7F);
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL tmo_status_clr got=%h want=00", tx_data); end
    tick();
  endtask

  task automatic test_timeout_edge();
    send(8'h80);
    tick(TMO - 1);
    send(8'h77);
    total++; if (regs_out !== 32'h003CA577) begin bad++; $display("FAIL tmo_edge_regs got=%h want=003ca577", regs_out); end
    total++; if (wr_strobe !== 1'b1) begin bad++; $display("FAIL tmo_edge_strobe got=%b want=1", wr_strobe); end
    send(8'h7F);
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL tmo_edge_status got=%h want=00", tx_data); end
    tick();
  endtask

  task automatic test_overrun_badaddr();
    tx_busy = 1'b1;
    send(8'h01);
    send(8'h33);
    tx_busy = 1'b0;
    #1;
    total++; if (tx_en !== 1'b1) begin bad++; $display("FAIL ovr_tx_en got=%b want=1", tx_en); end
    total++; if (tx_data !== 8'hA5) begin bad++; $display("FAIL ovr_tx_data got=%h want=a5", tx_data); end
    tick();
    send(8'h7F);
    total++; if (tx_data !== 8'h01) begin bad++; $display("FAIL ovr_status got=%h want=01", tx_data); end
    tick();
    tx_busy = 1'b1;
    send(8'h03);
    send(8'hFF);
    send(8'h00);
    tx_busy = 1'b0;
    tick();
    send(8'hFF);
    send(8'h00);
    send(8'h7F);
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL stwr_clear got=%h want=00", tx_data); end
    tick();
    total++; if (regs_out !== 32'h003CA577) begin bad++; $display("FAIL ovr_regs got=%h want=003ca577", regs_out); end
    send(8'h90);
    send(8'h11);
    total++; if (wr_strobe !== 1'b0) begin bad++; $display("FAIL bad_wr_strobe got=%b want=0", wr_strobe); end
    total++; if (regs_out !== 32'h003CA577) begin bad++; $display("FAIL bad_wr_regs got=%h want=003ca577", regs_out); end
    send(8'h7F);
    total++; if (tx_data !== 8'h04) begin bad++; $display("FAIL bad_status got=%h want=04", tx_data); end
    tick();
  endtask

  task automatic test_back_to_back();
    send(8'h83);
    send(8'h5A);
    send(8'h81);
    send(8'hC3);
    total++; if (regs_out !== 32'h5A3CC377) begin bad++; $display("FAIL b2b_regs got=%h want=5a3cc377", regs_out); end
    total++; if (wr_addr !== 7'h01) begin bad++; $display("FAIL b2b_wr_addr got=%h want=01", wr_addr); end
    tick();
  endtask

  task automatic test_reset_mid();
    send(8'h83);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (regs_out !== 32'h0) begin bad++; $display("FAIL rmid_regs got=%h want=0", regs_out); end
    total++; if (tx_en !== 1'b0) begin bad++; $display("FAIL rmid_tx_en got=%b want=0", tx_en); end
    send(8'h55);
    total++; if (tx_en !== 1'b1) begin bad++; $display("FAIL rmid_rd_tx_en got=%b want=1", tx_en); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rmid_rd_data got=%h want=00", tx_data); end
    tick();
    send(8'h7F);
    total++; if (tx_data !== 8'h04) begin bad++; $display("FAIL rmid_status got=%h want=04", tx_data); end
    tick();
    tx_busy = 1'b1;
    send(8'h02);
    tx_busy = 1'b0;
    reset   = 1'b1;
    #1;
    total++; if (tx_en !== 1'b0) begin bad++; $display("FAIL rresp_tx_en got=%b want=0", tx_en); end
    tick();
    reset = 1'b0;
    #1;
    total++; if (tx_en !== 1'b0) begin bad++; $display("FAIL rresp_after_tx_en got=%b want=0", tx_en); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rresp_tx_data got=%h want=00", tx_data); end
    tick();
  endtask

  initial begin
    tick();
    test_reset();
    test_write();
    test_read();
    test_busy();
    test_timeout();
    test_timeout_edge();
    test_overrun_badaddr();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
